bcd_countdown: RTL and testbench

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

---
 rtl/bcd_countdown.sv | 106 ++++++++++
 tb/tb_bcd_countdown.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown.sv
// rtl/bcd_countdown.sv - two-digit BCD down-counter with load, start, enable and optional auto-reload
module bcd_countdown #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       en,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [3:0] tens_n;
  logic [3:0] ones_n;
  logic [7:0] reload;
  logic [7:0] reload_n;
  logic       is_zero;
  logic       is_one;

  // A loaded digit above 9 is not BCD; saturate it to 9 instead.
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign is_zero = (tens == 4'd0) && (ones == 4'd0);
  assign is_one  = (tens == 4'd0) && (ones == 4'd1);

  // Next state and next count; load overrides everything except reset.
  always_comb begin
    state_n  = state;
    tens_n   = tens;
    ones_n   = ones;
    reload_n = reload;
    if (load) begin
      tens_n   = clamp9(load_val[7:4]);
      ones_n   = clamp9(load_val[3:0]);
      reload_n = {clamp9(load_val[7:4]), clamp9(load_val[3:0])};
      state_n  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = is_zero ? DONE : RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (is_zero) begin
              // Never borrow below 00; finish instead of wrapping to 99.
              state_n = DONE;
            end else if (is_one) begin
              ones_n  = 4'd0;
              state_n = DONE;
            end else if (ones != 4'd0) begin
              ones_n = ones - 4'd1;
            end else begin
              ones_n = 4'd9;
              tens_n = tens - 4'd1;
            end
          end
        end
        DONE: begin
          if (AUTO_RELOAD && (reload != 8'h00)) begin
            tens_n  = reload[7:4];
            ones_n  = reload[3:0];
            state_n = RUN;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, count and reload registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tens   <= 4'd0;
      ones   <= 4'd0;
      reload <= 8'h00;
    end else begin
      state  <= state_n;
      tens   <= tens_n;
      ones   <= ones_n;
      reload <= reload_n;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_countdown.sv
// tb/tb_bcd_countdown.sv - scoreboard bench for bcd_countdown, both reload modes
module tb_bcd_countdown;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       start = 1'b0;
  logic       en = 1'b0;
  logic [3:0] tens0, ones0, tens1, ones1;
  logic       busy0, done0, busy1, done1;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] o;
    logic       b;
    logic       d;
  } exp_t;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  exp_t q0[$];
  exp_t q1[$];
  int   cnt[2];
  int   rl[2];
  int   ph[2];
  int   total = 0;
  int   bad = 0;

  bcd_countdown #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .en(en),
    .tens(tens0), .ones(ones0), .busy(busy0), .done(done0)
  );

  bcd_countdown #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .en(en),
    .tens(tens1), .ones(ones1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  // Compare one observed output set against the expected one.
  task automatic check(input string name, input exp_t want, input exp_t got);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0d: got tens=%0d ones=%0d busy=%0b done=%0b, want tens=%0d ones=%0d busy=%0b done=%0b",
               name, $time, got.t, got.o, got.b, got.d, want.t, want.o, want.b, want.d);
    end
  endtask

  // Reference model: count kept as a plain integer 0..99.
  task automatic model(input int i, input bit ar, input logic r, input logic l,
                       input logic [7:0] v, input logic s, input logic e);
    int t;
    int o;
    if (r) begin
      cnt[i] = 0; rl[i] = 0; ph[i] = P_IDLE;
    end else if (l) begin
      t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
      o = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
      cnt[i] = t * 10 + o;
      rl[i] = cnt[i];
      ph[i] = P_IDLE;
    end else if (ph[i] == P_IDLE) begin
      if (s) ph[i] = (cnt[i] != 0) ? P_RUN : P_DONE;
    end else if (ph[i] == P_RUN) begin
      if (e) begin
        if (cnt[i] > 0) cnt[i] = cnt[i] - 1;
        if (cnt[i] == 0) ph[i] = P_DONE;
      end
    end else begin
      if (ar && rl[i] != 0) begin
        cnt[i] = rl[i];
        ph[i] = P_RUN;
      end else begin
        ph[i] = P_IDLE;
      end
    end
  endtask

  function automatic exp_t expect_of(input int i);
    exp_t x;
    x.t = 4'(cnt[i] / 10);
    x.o = 4'(cnt[i] % 10);
    x.b = (ph[i] == P_RUN);
    x.d = (ph[i] == P_DONE);
    return x;
  endfunction

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic step(input logic r, input logic l, input logic [7:0] v, input logic s, input logic e);
    @(negedge clk);
    #2;
    rst = r; load = l; load_val = v; start = s; en = e;
    model(0, 1'b0, r, l, v, s, e);
    model(1, 1'b1, r, l, v, s, e);
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  // Assert reset between edges and confirm outputs clear before any edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; load = 1'b0; start = 1'b0; en = 1'b0;
    #1;
    check("async_rst_ar0", exp_t'(0), {tens0, ones0, busy0, done0});
    check("async_rst_ar1", exp_t'(0), {tens1, ones1, busy1, done1});
    model(0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    model(1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  // Monitor: every cycle the DUTs present outputs; pop and compare.
  always @(negedge clk) begin
    if (q0.size() > 0) check("ar0", q0.pop_front(), {tens0, ones0, busy0, done0});
    if (q1.size() > 0) check("ar1", q1.pop_front(), {tens1, ones1, busy1, done1});
  end

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; rl[i] = 0; ph[i] = P_IDLE;
    end
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    // Full countdown from 12.
    step(0, 1, 8'h12, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    for (int k = 0; k < 16; k++) step(0, 0, 8'h00, 0, 1);
    // Borrow and clamp.
    step(0, 1, 8'h20, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'hAF, 0, 0);
    step(0, 0, 8'h00, 0, 1);
    // Enable gating, with start ignored in RUN.
    step(0, 1, 8'h05, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 1);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 1);
    // Auto-reload from 03.
    step(0, 1, 8'h03, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 8'h00, 0, 1);
    // Zero start.
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 0);
    // Load colliding with the 01 -> 00 step.
    step(0, 1, 8'h02, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'h07, 0, 1);
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 0);
    // Asynchronous reset while running at 37.
    step(0, 1, 8'h37, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    async_reset();
    step(1, 0, 8'h00, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 8'h00, 0, 1);
    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 1) v = 8'($urandom);
      else v = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 399) == 0) async_reset();
      else step(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) == 0), v,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end
    step(0, 0, 8'h00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
